// File: rtl/regfile.sv
// regfile: 32 x 64-bit LEGv8 register file, two combinational read ports, one write port.
// X0-X30 reset to their own index; address 31 is XZR (no storage, reads zero).
module regfile (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        we3,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa3,
  input  logic [63:0] wd3,
  output logic [63:0] rd1,
  output logic [63:0] rd2
);
  logic [63:0] regs [0:30];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)
      for (int i = 0; i < 31; i++) regs[i] <= 64'(i);
    else if (we3 && wa3 != 5'd31)
      regs[wa3] <= wd3;
  always_comb begin
    rd1 = (ra1 == 5'd31) ? 64'd0 : regs[ra1];
    rd2 = (ra2 == 5'd31) ? 64'd0 : regs[ra2];
  end
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed and randomized checks of regfile against an array reference model.
module tb_regfile;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        we3 = 1'b0;
  logic [4:0]  ra1 = '0, ra2 = '0, wa3 = '0;
  logic [63:0] wd3 = '0;
  logic [63:0] rd1, rd2;
  logic [63:0] m [0:31];
  int n_cmp = 0;
  int n_err = 0;

  regfile dut (
    .clk(clk), .reset_n(reset_n), .we3(we3), .ra1(ra1), .ra2(ra2),
    .wa3(wa3), .wd3(wd3), .rd1(rd1), .rd2(rd2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m[i] = (i == 31) ? 64'd0 : 64'(i);
  endtask

  task automatic model_write(input logic en, input logic [4:0] a, input logic [63:0] d);
    if (en && a != 5'd31) m[a] = d;
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      ra2 = 5'(31 - i);
      #1;
      check($sformatf("%s_rd1_x%0d", tag, i), rd1, m[i]);
      check($sformatf("%s_rd2_x%0d", tag, 31 - i), rd2, m[31 - i]);
    end
  endtask

  initial begin
    logic [63:0] d;
    logic [4:0]  a, b;
    logic        e;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    ra1 = 5'd0;
    ra2 = 5'd30;
    #1;
    check("reset_rd1_x0", rd1, 64'd0);
    check("reset_rd2_x30", rd2, 64'd30);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 31; i++) begin
      ra1 = 5'(i);
      ra2 = 5'(i);
      #1;
      check($sformatf("post_reset_rd1_x%0d", i), rd1, 64'(i));
      check($sformatf("post_reset_rd2_x%0d", i), rd2, 64'(i));
    end
    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      d = {$urandom, $urandom};
      we3 = 1'b1;
      wa3 = 5'(i);
      wd3 = d;
      ra1 = 5'(i);
      ra2 = 5'(i);
      #1;
      check($sformatf("pre_edge_old_x%0d", i), rd1, m[i]);
      @(posedge clk);
      #1;
      model_write(1'b1, 5'(i), d);
      check($sformatf("write_rd1_x%0d", i), rd1, d);
      check($sformatf("write_rd2_x%0d", i), rd2, d);
    end
    @(negedge clk);
    we3 = 1'b0;
    ra1 = 5'd31;
    ra2 = 5'd31;
    #1;
    check("xzr_after_sweep_rd1", rd1, 64'd0);
    check("xzr_after_sweep_rd2", rd2, 64'd0);
    @(negedge clk);
    we3 = 1'b1;
    wa3 = 5'd31;
    wd3 = 64'd1;
    @(posedge clk);
    #1;
    model_write(1'b1, 5'd31, 64'd1);
    @(negedge clk);
    we3 = 1'b0;
    sweep("xzr_write");
    @(negedge clk);
    we3 = 1'b1;
    wa3 = 5'd7;
    wd3 = 64'h1234;
    @(posedge clk);
    #1;
    model_write(1'b1, 5'd7, 64'h1234);
    ra1 = 5'd7;
    #1;
    check("x7_written", rd1, 64'h1234);
    we3 = 1'b0;
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("async_reset_x7", rd1, 64'd7);
    @(negedge clk);
    we3 = 1'b1;
    wa3 = 5'd3;
    wd3 = 64'hFFFF_0000_FFFF_0000;
    repeat (2) @(posedge clk);
    #1;
    ra1 = 5'd3;
    #1;
    check("write_blocked_in_reset_x3", rd1, 64'd3);
    @(negedge clk);
    we3 = 1'b0;
    reset_n = 1'b1;
    sweep("after_reset");
    @(negedge clk);
    we3 = 1'b0;
    wa3 = 5'd5;
    wd3 = 64'hDEAD_BEEF;
    @(posedge clk);
    #1;
    ra1 = 5'd5;
    ra2 = 5'd5;
    #1;
    check("we_off_rd1_x5", rd1, 64'd5);
    check("we_off_rd2_x5", rd2, 64'd5);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      e = 1'($urandom);
      a = 5'($urandom);
      b = 5'($urandom);
      d = {$urandom, $urandom};
      we3 = e;
      wa3 = a;
      wd3 = d;
      ra1 = b;
      ra2 = a;
      #1;
      check($sformatf("rand%0d_pre_rd1", k), rd1, m[b]);
      check($sformatf("rand%0d_pre_rd2", k), rd2, m[a]);
      @(posedge clk);
      #1;
      model_write(e, a, d);
      check($sformatf("rand%0d_post_rd1", k), rd1, m[b]);
      check($sformatf("rand%0d_post_rd2", k), rd2, m[a]);
    end
    @(negedge clk);
    we3 = 1'b0;
    sweep("final");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
